// File: rtl/conv_calc_pkg.sv
// Shared helpers for the convolution MAC engine: sum-growth table and width helpers.
// The optional ReLU stage is enabled by the CONV_CALC_RELU_EN macro (see conv_layer_calc).
package conv_calc_pkg;

  // Growth bits needed so that KERNEL^2 products never overflow the sum.
  function automatic int calc_ext(input int kernel);
    case (kernel)
      1:       return 0;
      3:       return 3;
      5:       return 5;
      7:       return 6;
      default: return -1;
    endcase
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Operand count after one layer of 3:2 compressors.
  function automatic int csa_next(input int c);
    return c - c / 3;
  endfunction

  function automatic int csa_levels(input int n);
    int c;
    int l;
    c = n;
    l = 0;
    while (c > 2) begin
      c = csa_next(c);
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/carry_save_adder.sv
// Combinational N-operand signed adder: sign-extend, 3:2 compressor tree to two
// vectors, then one carry-propagate add.
module carry_save_adder
  import conv_calc_pkg::*;
#(
  parameter int N = 9,
  parameter int W = 4,
  parameter int E = 3
) (
  input  logic [N*W-1:0] a,
  output logic [W+E-1:0] sum,
  output logic           cout
);

  localparam int SW = W + E;
  localparam int LV = csa_levels(N);

  logic [SW-1:0] lvl [0:LV][0:N-1];
  logic [SW-1:0] f0;
  logic [SW-1:0] f1;

  always_comb begin
    int c;
    int g;
    logic [SW-1:0] x;
    logic [SW-1:0] y;
    logic [SW-1:0] z;
    for (int l = 0; l <= LV; l++)
      for (int i = 0; i < N; i++)
        lvl[l][i] = '0;
    for (int i = 0; i < N; i++)
      lvl[0][i] = SW'($signed(a[i*W +: W]));
    c = N;
    for (int l = 0; l < LV; l++) begin
      g = c / 3;
      for (int i = 0; i < N; i++) begin
        x = lvl[l][i];
        y = '0;
        z = '0;
        if (i < g) begin
          x = lvl[l][3*i];
          y = lvl[l][3*i+1];
          z = lvl[l][3*i+2];
          lvl[l+1][2*i]   = x ^ y ^ z;
          lvl[l+1][2*i+1] = ((x & y) | (x & z) | (y & z)) << 1;
        end else if (i >= 3*g && i < c) begin
          // operands left over from the groups of three pass straight down
          lvl[l+1][i-g] = x;
        end
      end
      c = csa_next(c);
    end
  end

  assign f0 = lvl[LV][0];

  if (N > 1) begin : g_two
    assign f1 = lvl[LV][1];
  end else begin : g_one
    assign f1 = '0;
  end

  assign {cout, sum} = {1'b0, f0} + {1'b0, f1};

endmodule

// File: rtl/conv_layer_calc.sv
// Single-channel KERNELxKERNEL signed MAC, two-stage pipeline, one window per clock.
// Define CONV_CALC_RELU_EN to clamp negative sums to zero in the output stage.
module conv_layer_calc
  import conv_calc_pkg::*;
#(
  parameter int KERNEL = 3,
  parameter int E      = 3,
  parameter int N      = 2,
  parameter int M      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [KERNEL*KERNEL*N-1:0]   data2conv,
  input  logic                         en_in,
  input  logic [KERNEL*KERNEL*M-1:0]   w,
  output logic [N+M+E-1:0]             d_out,
  output logic                         en_out
);

  localparam int K2 = KERNEL * KERNEL;
  localparam int PW = N + M;
  localparam int OW = N + M + E;

  if (E != calc_ext(KERNEL)) begin : g_bad_cfg
    $error("conv_layer_calc: E does not match calc_ext(KERNEL)");
  end

  logic [K2-1:0][PW-1:0] prod;
  logic [K2-1:0][PW-1:0] prod_q;
  logic [2:1]            vld_pipe;
  logic [OW-1:0]         sum_s;
  logic [OW-1:0]         d_next;

  for (genvar k = 0; k < K2; k++) begin : g_lane
    logic signed [PW-1:0] ax;
    logic signed [PW-1:0] wx;
    assign ax = {{M{data2conv[k*N+N-1]}}, data2conv[k*N +: N]};
    assign wx = {{N{w[k*M+M-1]}}, w[k*M +: M]};
    // full product fits in N+M bits, so the truncation is exact
    assign prod[k] = ax * wx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q   <= '0;
      vld_pipe <= '0;
    end else begin
      prod_q   <= prod;
      vld_pipe <= {vld_pipe[1], en_in};
    end
  end

  if (K2 == 1) begin : g_bypass
    assign sum_s = OW'($signed(prod_q[0]));
  end else begin : g_tree
    logic unused_cout;
    carry_save_adder #(.N(K2), .W(PW), .E(E)) u_csa (
      .a    (prod_q),
      .sum  (sum_s),
      .cout (unused_cout)
    );
  end

`ifdef CONV_CALC_RELU_EN
  assign d_next = sum_s[OW-1] ? '0 : sum_s;
`else
  assign d_next = sum_s;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) d_out <= '0;
    else      d_out <= d_next;
  end

  assign en_out = vld_pipe[2];

endmodule

// File: tb/tb_conv_layer_calc.sv
// Directed bench for conv_layer_calc: 3x3 instance plus a KERNEL=1 instance.
module tb_conv_layer_calc;

  logic        clk;
  logic        rst;
  logic [17:0] data;
  logic [17:0] wt;
  logic        en_in;
  logic [6:0]  d_out;
  logic        en_out;
  logic [1:0]  data1;
  logic [1:0]  wt1;
  logic        en_in1;
  logic [3:0]  d_out1;
  logic        en_out1;

  int checks;
  int failures;

  conv_layer_calc #(.KERNEL(3), .E(3), .N(2), .M(2)) dut (
    .clk(clk), .rst(rst), .data2conv(data), .en_in(en_in), .w(wt),
    .d_out(d_out), .en_out(en_out)
  );

  conv_layer_calc #(.KERNEL(1), .E(0), .N(2), .M(2)) dut_k1 (
    .clk(clk), .rst(rst), .data2conv(data1), .en_in(en_in1), .w(wt1),
    .d_out(d_out1), .en_out(en_out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CONV_CALC_RELU_EN
  localparam logic [6:0] EXP_NEG18 = 7'd0;
`else
  localparam logic [6:0] EXP_NEG18 = 7'b1101110;
`endif

  task automatic test_reset();
    rst = 1'b0; en_in = 1'b0; data = '0; wt = '0;
    en_in1 = 1'b0; data1 = '0; wt1 = '0;
    #1;
    checks++;
    if (d_out !== 7'd0 || en_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: d_out=%b en_out=%b, want 0000000/0", d_out, en_out);
    end
    checks++;
    if (d_out1 !== 4'd0 || en_out1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state_k1: d_out=%b en_out=%b, want 0000/0", d_out1, en_out1);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One window pulse; checks latency, value and single-cycle en_out.
  task automatic test_single(input string name, input logic [17:0] d,
                             input logic [17:0] ww, input logic [6:0] exp_v);
    @(negedge clk);
    data = d; wt = ww; en_in = 1'b1;
    @(negedge clk);
    en_in = 1'b0; data = '0; wt = '0;
    checks++;
    if (en_out !== 1'b0) begin
      failures++;
      $display("FAIL %s_early: en_out=%b after 1 edge, want 0", name, en_out);
    end
    @(negedge clk);
    checks++;
    if (en_out !== 1'b1 || d_out !== exp_v) begin
      failures++;
      $display("FAIL %s: en_out=%b d_out=%b, want 1/%b", name, en_out, d_out, exp_v);
    end
    @(negedge clk);
    checks++;
    if (en_out !== 1'b0) begin
      failures++;
      $display("FAIL %s_pulse: en_out=%b on 3rd edge, want 0", name, en_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] dv [3];
    logic [17:0] wv [3];
    logic [6:0]  ev [3];
    dv[0] = {9{2'b01}}; wv[0] = {9{2'b01}}; ev[0] = 7'd9;
    dv[1] = {9{2'b10}}; wv[1] = {9{2'b10}}; ev[1] = 7'd36;
    dv[2] = {9{2'b11}}; wv[2] = {9{2'b10}}; ev[2] = 7'd18;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      data = dv[i]; wt = wv[i]; en_in = 1'b1;
      @(negedge clk);
      if (i >= 1) begin
        checks++;
        if (en_out !== 1'b1 || d_out !== ev[i-1]) begin
          failures++;
          $display("FAIL stream_%0d: en_out=%b d_out=%0d, want 1/%0d", i-1, en_out, d_out, ev[i-1]);
        end
      end
    end
    en_in = 1'b0; data = '0; wt = '0;
    @(negedge clk);
    checks++;
    if (en_out !== 1'b1 || d_out !== ev[2]) begin
      failures++;
      $display("FAIL stream_2: en_out=%b d_out=%0d, want 1/%0d", en_out, d_out, ev[2]);
    end
    @(negedge clk);
    checks++;
    if (en_out !== 1'b0) begin
      failures++;
      $display("FAIL stream_end: en_out=%b, want 0", en_out);
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    data = {9{2'b01}}; wt = {9{2'b01}}; en_in = 1'b1;
    @(negedge clk);
    data = {9{2'b10}}; wt = {9{2'b10}};
    @(negedge clk);
    checks++;
    if (en_out !== 1'b1 || d_out !== 7'd9) begin
      failures++;
      $display("FAIL midrst_pre: en_out=%b d_out=%0d, want 1/9", en_out, d_out);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (en_out !== 1'b0 || d_out !== 7'd0) begin
      failures++;
      $display("FAIL midrst_async: en_out=%b d_out=%0d, want 0/0", en_out, d_out);
    end
    en_in = 1'b0; data = '0; wt = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (en_out !== 1'b0) begin
        failures++;
        $display("FAIL midrst_stale_%0d: en_out=%b, want 0", i, en_out);
      end
    end
  endtask

  task automatic test_kernel1();
    @(negedge clk);
    data1 = 2'b10; wt1 = 2'b10; en_in1 = 1'b1;
    @(negedge clk);
    en_in1 = 1'b0; data1 = 2'b01; wt1 = 2'b01;
    checks++;
    if (en_out1 !== 1'b0) begin
      failures++;
      $display("FAIL k1_early: en_out=%b, want 0", en_out1);
    end
    @(negedge clk);
    checks++;
    if (en_out1 !== 1'b1 || d_out1 !== 4'b0100) begin
      failures++;
      $display("FAIL k1_value: en_out=%b d_out=%b, want 1/0100", en_out1, d_out1);
    end
    data1 = '0; wt1 = '0;
    @(negedge clk);
    checks++;
    if (en_out1 !== 1'b0) begin
      failures++;
      $display("FAIL k1_pulse: en_out=%b, want 0", en_out1);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single("ones", {9{2'b01}}, {9{2'b01}}, 7'd9);
    test_single("max_pos", {9{2'b10}}, {9{2'b10}}, 7'b0100100);
    test_single("neg18", {9{2'b10}}, {9{2'b01}}, EXP_NEG18);
    // k0: -2*-1=2, k4: 1*-2=-2, k8: -1*-1=1 -> 1
    test_single("mixed", 18'b11_00_00_00_01_00_00_00_10,
                         18'b11_00_00_00_10_00_00_00_11, 7'd1);
    test_back_to_back();
    test_reset_midstream();
    test_kernel1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
